tt_scan_ctrl: RTL and testbench

TT_SCAN_CTRL -- requirements
Module: tt_scan_ctrl

---
 rtl/tt_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_tt_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_scan_ctrl.sv
// Truth-table scanner: steps a 4-input vector through 0..15, capturing f_in per vector.
// Optional self-check against an expected table is enabled by defining TT_SCAN_COMPARE_EN.
module tt_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
`ifdef TT_SCAN_COMPARE_EN
    input  logic [15:0] expected,
    output logic        match,
    output logic [4:0]  mismatch_cnt,
`endif
    output logic [3:0]  x_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table
);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_tt;
    logic        w_accept;
    logic        w_sample;
    logic        w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort is evaluated before the sample so it wins a same-edge collision.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_abort      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            StIdle: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_state_next = StApply;
                end
            end
            StApply: begin
                busy = 1'b1;
                if (abort) begin
                    w_abort      = 1'b1;
                    w_state_next = StIdle;
                end else if (r_cnt == CntLast) begin
                    w_sample = 1'b1;
                    if (r_idx == 4'd15) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 4'd0;
            r_cnt <= 4'd0;
            r_tt  <= 16'd0;
        end else if (w_accept) begin
            r_idx <= 4'd0;
            r_cnt <= 4'd0;
            r_tt  <= 16'd0;
        end else if (w_abort) begin
            r_idx <= 4'd0;
            r_cnt <= 4'd0;
        end else if (w_sample) begin
            r_tt[r_idx] <= f_in;
            r_cnt       <= 4'd0;
            if (r_idx != 4'd15) begin
                r_idx <= r_idx + 4'd1;
            end
        end else if (r_state == StApply) begin
            r_cnt <= r_cnt + 4'd1;
        end else if (r_state == StDone) begin
            r_idx <= 4'd0;
        end
    end

    assign x_out       = r_idx;
    assign truth_table = r_tt;

`ifdef TT_SCAN_COMPARE_EN
    logic [15:0] r_exp;
    logic [4:0]  r_mm_cnt;
    logic        r_match;
    logic [4:0]  w_mm_next;

    assign w_mm_next = r_mm_cnt + 5'((w_sample && (f_in != r_exp[r_idx])) ? 1 : 0);

    // The verdict includes the final sample, so it uses the post-increment count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp    <= 16'd0;
            r_mm_cnt <= 5'd0;
            r_match  <= 1'b0;
        end else if (w_accept) begin
            r_exp    <= expected;
            r_mm_cnt <= 5'd0;
            r_match  <= 1'b0;
        end else begin
            if (w_sample) begin
                r_mm_cnt <= w_mm_next;
            end
            if (w_abort) begin
                r_match <= 1'b0;
            end else if (w_sample && r_idx == 4'd15) begin
                r_match <= (w_mm_next == 5'd0);
            end
        end
    end

    assign match        = r_match;
    assign mismatch_cnt = r_mm_cnt;
`endif

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Self-checking bench for tt_scan_ctrl: f_in is a lookup into a random function table,
// and the expected capture is that table masked by how many vectors should have been sampled.
module tb_tt_scan_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        f_in;
    logic [3:0]  x_out;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [15:0] ftab;
    logic [15:0] expected;
`ifdef TT_SCAN_COMPARE_EN
    logic        match;
    logic [4:0]  mismatch_cnt;
`endif

    int n_tests;
    int n_fail;

    assign f_in = ftab[x_out];

    tt_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .f_in        (f_in),
`ifdef TT_SCAN_COMPARE_EN
        .expected    (expected),
        .match       (match),
        .mismatch_cnt(mismatch_cnt),
`endif
        .x_out       (x_out),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] low_mask(input int n);
        logic [31:0] m;
        if (n >= 16) return 16'hFFFF;
        if (n <= 0) return 16'h0000;
        m = (32'd1 << n) - 32'd1;
        return m[15:0];
    endfunction

    // Runs one scan from IDLE. restart_t / abort_t are observation indices (-1 = none);
    // observation t reflects the state after edge k+t, where k is the start-accept edge.
    task automatic do_scan(input logic [15:0] tab, input int restart_t, input int abort_t,
                           input logic [15:0] exp_tab, input string name);
        int          last;
        int          nmm;
        logic [15:0] want;
        last     = 16 * S;
        ftab     = tab;
        expected = exp_tab;
        nmm      = $countones(tab ^ exp_tab);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= last + 1; t++) begin
            if (abort_t >= 0 && t == abort_t) begin
                abort = 1'b0;
                want  = tab & low_mask((t - 1) / S);
                n_tests++;
                if ({busy, done, x_out} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_idle t=%0d busy/done/x=%b want 000000", name, t,
                             {busy, done, x_out});
                end
                n_tests++;
                if (truth_table !== want) begin
                    n_fail++;
                    $display("FAIL %s abort_table got %h want %h", name, truth_table, want);
                end
`ifdef TT_SCAN_COMPARE_EN
                n_tests++;
                if (match !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_match got %b want 0", name, match);
                end
`endif
                for (int j = 0; j < last - t + 3; j++) begin
                    @(negedge clk);
                    n_tests++;
                    if ({busy, done, truth_table} !== {2'b00, want}) begin
                        n_fail++;
                        $display("FAIL %s post_abort busy=%b done=%b tt=%h want 0 0 %h", name,
                                 busy, done, truth_table, want);
                    end
                end
                return;
            end
            if (t < last) begin
                want = tab & low_mask(t / S);
                n_tests++;
                if ({busy, done, x_out} !== {2'b10, 4'(t / S)}) begin
                    n_fail++;
                    $display("FAIL %s apply t=%0d busy/done/x=%b want %b", name, t,
                             {busy, done, x_out}, {2'b10, 4'(t / S)});
                end
                n_tests++;
                if (truth_table !== want) begin
                    n_fail++;
                    $display("FAIL %s partial t=%0d got %h want %h", name, t, truth_table, want);
                end
`ifdef TT_SCAN_COMPARE_EN
                n_tests++;
                if (match !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s apply_match t=%0d got %b want 0", name, t, match);
                end
`endif
            end else if (t == last) begin
                n_tests++;
                if ({busy, done, truth_table} !== {2'b01, tab}) begin
                    n_fail++;
                    $display("FAIL %s done busy=%b done=%b tt=%h want 0 1 %h", name, busy, done,
                             truth_table, tab);
                end
`ifdef TT_SCAN_COMPARE_EN
                n_tests++;
                if ({match, mismatch_cnt} !== {(nmm == 0), 5'(nmm)}) begin
                    n_fail++;
                    $display("FAIL %s verdict match=%b cnt=%0d want %b %0d", name, match,
                             mismatch_cnt, (nmm == 0), nmm);
                end
`endif
            end else begin
                n_tests++;
                if ({busy, done, x_out, truth_table} !== {6'b0, tab}) begin
                    n_fail++;
                    $display("FAIL %s idle_after busy=%b done=%b x=%h tt=%h want 0 0 0 %h", name,
                             busy, done, x_out, truth_table, tab);
                end
`ifdef TT_SCAN_COMPARE_EN
                n_tests++;
                if (match !== (nmm == 0)) begin
                    n_fail++;
                    $display("FAIL %s match_hold got %b want %b", name, match, (nmm == 0));
                end
`endif
            end
            start = (t == restart_t);
            if (abort_t >= 0 && t == abort_t - 1) abort = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({busy, done, x_out, truth_table} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset outputs got %h want 0", {busy, done, x_out, truth_table});
        end
`ifdef TT_SCAN_COMPARE_EN
        n_tests++;
        if ({match, mismatch_cnt} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_cmp got %b want 0", {match, mismatch_cnt});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_patterns;
        do_scan(16'hAAAA, -1, -1, 16'hAAAA, "x4");
        do_scan(16'hCC00, -1, -1, 16'hCC00, "x1andx3");
    endtask

    task automatic test_restart;
        do_scan(16'h5A3C, 10, -1, 16'h5A3C, "restart_v5");
        do_scan(16'h0F0F, 16 * S, -1, 16'h0F0F, "restart_done");
    endtask

    task automatic test_abort;
        do_scan(16'hFFFF, -1, 16, 16'hFFFF, "abort_v7");
        do_scan(16'($urandom), -1, 1 + $urandom_range(0, 16 * S - 2), 16'h0, "abort_rand");
    endtask

    task automatic test_idle_controls;
        logic [15:0] held;
        held = truth_table;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({busy, truth_table} !== {1'b0, held}) begin
            n_fail++;
            $display("FAIL start_abort_idle busy=%b tt=%h want 0 %h", busy, truth_table, held);
        end
        repeat (3) @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if ({busy, done, x_out, truth_table} !== {6'b0, held}) begin
            n_fail++;
            $display("FAIL idle_hold got %h want %h", {busy, done, x_out, truth_table},
                     {6'b0, held});
        end
    endtask

    task automatic test_reset_mid;
        ftab = 16'h9669;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, x_out, truth_table} !== 22'b0) begin
            n_fail++;
            $display("FAIL mid_reset got %h want 0", {busy, done, x_out, truth_table});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({busy, done, x_out, truth_table} !== 22'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %h want 0", {busy, done, x_out, truth_table});
        end
        do_scan(16'h9669, -1, -1, 16'h9669, "after_reset");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            do_scan(16'($urandom), -1, -1, 16'($urandom), "random");
        end
    endtask

    task automatic test_compare;
        do_scan(16'hAAAA, -1, -1, 16'hAAAA, "cmp_ok");
        do_scan(16'hAAAA, -1, -1, 16'hAAAB, "cmp_one");
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        start    = 1'b0;
        abort    = 1'b0;
        ftab     = 16'h0;
        expected = 16'h0;
        test_reset();
        test_patterns();
        test_idle_controls();
        test_restart();
        test_abort();
        test_idle_controls();
        test_reset_mid();
        test_back_to_back();
        test_compare();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
